// File: rtl/axil_read_slave.sv
// AXI4-Lite read-only responder in front of a bank of NREG 32-bit registers.
// Local logic writes the bank through a strobe port; rd_pulse flags accepted in-range reads.
module axil_read_slave #(
  parameter int          NREG      = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_areset,
  input  logic [31:0]              s_axi_araddr,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  input  logic                     reg_wvalid,
  input  logic [$clog2(NREG)-1:0]  reg_widx,
  input  logic [31:0]              reg_wdata,
  output logic                     rd_pulse,
  output logic [$clog2(NREG)-1:0]  rd_idx
);

  localparam int          IW   = $clog2(NREG);
  localparam logic [31:0] SPAN = 32'(NREG * 4);

  typedef enum logic [2:0] {
    ST_RESET = 3'b001,
    ST_IDLE  = 3'b010,
    ST_RESP  = 3'b100
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [31:0]   r_bank [NREG];
  logic [31:0]   r_rdata;
  logic [1:0]    r_rresp;
  logic          r_arready;
  logic          r_rvalid;
  logic          r_rd_pulse;
  logic [IW-1:0] r_rd_idx;

  logic [31:0]   w_off;
  logic [IW-1:0] w_idx;
  logic          w_in_range;
  logic          w_ar_hs;

  assign w_off      = s_axi_araddr - BASE_ADDR;
  assign w_idx      = w_off[IW+1:2];
  assign w_in_range = (w_off[1:0] == 2'b00) && (w_off < SPAN);
  assign w_ar_hs    = (r_state == ST_IDLE) && s_axi_arvalid;

  // Local write port is independent of the AXI side; a same-edge read sees the old word.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_bank
      always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
          r_bank[gi] <= 32'h0;
        end else if (reg_wvalid && (reg_widx == IW'(gi))) begin
          r_bank[gi] <= reg_wdata;
        end
      end
    end
  endgenerate

  always_comb begin
    w_state_next = ST_RESET;
    case (r_state)
      ST_RESET: w_state_next = ST_IDLE;
      ST_IDLE:  w_state_next = s_axi_arvalid ? ST_RESP : ST_IDLE;
      ST_RESP:  w_state_next = s_axi_rready  ? ST_IDLE : ST_RESP;
      default:  w_state_next = ST_RESET;
    endcase
  end

  // Handshake flags are registered from the next state so they line up with r_state.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state   <= ST_RESET;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_arready <= (w_state_next == ST_IDLE);
      r_rvalid  <= (w_state_next == ST_RESP);
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_rdata    <= 32'h0;
      r_rresp    <= 2'b00;
      r_rd_pulse <= 1'b0;
      r_rd_idx   <= '0;
    end else begin
      r_rd_pulse <= w_ar_hs && w_in_range;
      if (w_ar_hs) begin
        r_rdata <= w_in_range ? r_bank[w_idx] : 32'h0;
        r_rresp <= w_in_range ? 2'b00 : 2'b10;
        if (w_in_range) begin
          r_rd_idx <= w_idx;
        end
      end
    end
  end

  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign rd_pulse      = r_rd_pulse;
  assign rd_idx        = r_rd_idx;

endmodule

// File: tb/tb_axil_read_slave.sv
// Directed bench for axil_read_slave: NREG=8 at a non-zero base, outputs sampled on the falling edge.
module tb_axil_read_slave;

  localparam int          NREG = 8;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        areset;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        wvalid;
  logic [2:0]  widx;
  logic [31:0] wdata;
  logic        rd_pulse;
  logic [2:0]  rd_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axil_read_slave #(.NREG(NREG), .BASE_ADDR(BASE)) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (areset),
    .s_axi_araddr (araddr),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata  (rdata),
    .s_axi_rresp  (rresp),
    .s_axi_rvalid (rvalid),
    .s_axi_rready (rready),
    .reg_wvalid   (wvalid),
    .reg_widx     (widx),
    .reg_wdata    (wdata),
    .rd_pulse     (rd_pulse),
    .rd_idx       (rd_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    areset = 1'b1; araddr = 32'h0; arvalid = 1'b0; rready = 1'b0;
    wvalid = 1'b0; widx = 3'd0; wdata = 32'h0;
    repeat (3) cyc();
    chk("rst_arready", {31'b0, arready}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rresp", {30'b0, rresp}, 32'd0);
    chk("rst_rd_pulse", {31'b0, rd_pulse}, 32'd0);
    chk("rst_rd_idx", {29'b0, rd_idx}, 32'd0);

    // Leave reset and write bank[3] on the same first edge
    areset = 1'b0; wvalid = 1'b1; widx = 3'd3; wdata = 32'hDEAD_BEEF;
    cyc();
    $display("step: reset exit, bank[3]=DEADBEEF");
    chk("arready_after_rst", {31'b0, arready}, 32'd1);
    wvalid = 1'b0; araddr = BASE + 32'h0C; arvalid = 1'b1; rready = 1'b1;
    cyc();
    $display("step: read 0x0C");
    chk("r1_rvalid", {31'b0, rvalid}, 32'd1);
    chk("r1_rdata", rdata, 32'hDEAD_BEEF);
    chk("r1_rresp", {30'b0, rresp}, 32'd0);
    chk("r1_rd_pulse", {31'b0, rd_pulse}, 32'd1);
    chk("r1_rd_idx", {29'b0, rd_idx}, 32'd3);
    chk("r1_arready", {31'b0, arready}, 32'd0);
    araddr = BASE + 32'h20;
    cyc();
    chk("r1_done_rvalid", {31'b0, rvalid}, 32'd0);
    chk("r1_done_arready", {31'b0, arready}, 32'd1);
    chk("r1_pulse_width", {31'b0, rd_pulse}, 32'd0);
    cyc();
    $display("step: read 0x20 out of range");
    chk("oor_rvalid", {31'b0, rvalid}, 32'd1);
    chk("oor_rresp", {30'b0, rresp}, 32'd2);
    chk("oor_rdata", rdata, 32'h0);
    chk("oor_rd_pulse", {31'b0, rd_pulse}, 32'd0);
    chk("oor_rd_idx_hold", {29'b0, rd_idx}, 32'd3);
    araddr = BASE + 32'h05;
    cyc();
    chk("oor_done_arready", {31'b0, arready}, 32'd1);
    cyc();
    $display("step: read 0x05 misaligned");
    chk("mis_rresp", {30'b0, rresp}, 32'd2);
    chk("mis_rdata", rdata, 32'h0);
    chk("mis_rd_pulse", {31'b0, rd_pulse}, 32'd0);
    arvalid = 1'b0;
    cyc();
    chk("mis_done_arready", {31'b0, arready}, 32'd1);

    // Stall the response while the register under read changes
    araddr = BASE + 32'h0C; arvalid = 1'b1; rready = 1'b0;
    cyc();
    $display("step: stalled read 0x0C");
    chk("st_rdata0", rdata, 32'hDEAD_BEEF);
    arvalid = 1'b0; wvalid = 1'b1; widx = 3'd3; wdata = 32'h1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      wvalid = 1'b0;
      chk("st_rvalid", {31'b0, rvalid}, 32'd1);
      chk("st_rdata", rdata, 32'hDEAD_BEEF);
      chk("st_arready", {31'b0, arready}, 32'd0);
    end
    rready = 1'b1;
    cyc();
    chk("st_done_rvalid", {31'b0, rvalid}, 32'd0);
    chk("st_done_arready", {31'b0, arready}, 32'd1);
    araddr = BASE + 32'h0C; arvalid = 1'b1;
    cyc();
    $display("step: reread 0x0C");
    chk("st_new_rdata", rdata, 32'h1);
    chk("st_new_rresp", {30'b0, rresp}, 32'd0);

    // bank[2]=5, then write 7 on the handshake edge of a read of index 2
    arvalid = 1'b0; wvalid = 1'b1; widx = 3'd2; wdata = 32'd5;
    cyc();
    wdata = 32'd7; araddr = BASE + 32'h08; arvalid = 1'b1;
    cyc();
    $display("step: read 0x08 with colliding write");
    chk("col_rdata_old", rdata, 32'd5);
    chk("col_rd_pulse", {31'b0, rd_pulse}, 32'd1);
    chk("col_rd_idx", {29'b0, rd_idx}, 32'd2);
    wvalid = 1'b0;
    cyc();
    chk("b2b_gap_rvalid", {31'b0, rvalid}, 32'd0);
    chk("b2b_gap_arready", {31'b0, arready}, 32'd1);
    cyc();
    $display("step: back-to-back read 0x08");
    chk("b2b_rvalid", {31'b0, rvalid}, 32'd1);
    chk("col_rdata_new", rdata, 32'd7);

    // Reset while a response is pending
    rready = 1'b0; arvalid = 1'b0; areset = 1'b1;
    cyc();
    $display("step: reset mid-response");
    chk("mrst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("mrst_arready", {31'b0, arready}, 32'd0);
    chk("mrst_rdata", rdata, 32'h0);
    chk("mrst_rd_idx", {29'b0, rd_idx}, 32'd0);
    areset = 1'b0;
    cyc();
    chk("mrst_arready_up", {31'b0, arready}, 32'd1);
    araddr = BASE + 32'h08; arvalid = 1'b1; rready = 1'b1;
    cyc();
    $display("step: post-reset read 0x08");
    chk("clr_b2_rdata", rdata, 32'h0);
    chk("clr_b2_rresp", {30'b0, rresp}, 32'd0);
    chk("clr_b2_rd_idx", {29'b0, rd_idx}, 32'd2);
    araddr = BASE + 32'h0C;
    cyc();
    cyc();
    $display("step: post-reset read 0x0C");
    chk("clr_b3_rdata", rdata, 32'h0);
    chk("clr_b3_rd_idx", {29'b0, rd_idx}, 32'd3);
    araddr = BASE - 32'h4;
    cyc();
    cyc();
    $display("step: read below base");
    chk("below_rresp", {30'b0, rresp}, 32'd2);
    chk("below_rd_pulse", {31'b0, rd_pulse}, 32'd0);
    arvalid = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
